// File: rtl/zap_ifetch_master_pkg.sv
// Shared types and helpers for the instruction-fetch bus master:
// FSM state encodings, per-cycle pipeline decision, and the word
// record that travels through the skid buffer toward fetch.
package zap_ifetch_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_STALLED  = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_ABORTED  = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        DEC_ADV     = 2'd0,
        DEC_HOLD    = 2'd1,
        DEC_CLR_WB  = 2'd2,
        DEC_CLR_ALU = 2'd3
    } fetch_decision_t;

    // Instruction word reported alongside an abort.
    localparam logic [31:0] ABORT_PAYLOAD   = 32'd0;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_BYTES      = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

    // Priority chain shared with the fetch stage: writeback clear, data
    // stall, ALU clear, then issue/decode stalls.
    function automatic fetch_decision_t decide(
        input logic clr_wb,
        input logic data_stall,
        input logic clr_alu,
        input logic stall_issue,
        input logic stall_decode
    );
        if (clr_wb)
            return DEC_CLR_WB;
        else if (data_stall)
            return DEC_HOLD;
        else if (clr_alu)
            return DEC_CLR_ALU;
        else if (stall_issue || stall_decode)
            return DEC_HOLD;
        else
            return DEC_ADV;
    endfunction

endpackage

// File: rtl/zap_ifetch_master_if.sv
// Wishbone-classic read-only instruction bus (cyc tied to stb).
interface zap_ifetch_master_if;
    logic        mem_stb;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_data;

    modport master (
        output mem_stb,
        output mem_addr,
        input  mem_ack,
        input  mem_err,
        input  mem_data
    );

    modport slave (
        input  mem_stb,
        input  mem_addr,
        output mem_ack,
        output mem_err,
        output mem_data
    );
endinterface

// File: rtl/zap_ifetch_skid.sv
// One-entry holding register for a response that lands while the
// pipeline is frozen. Flush beats load beats unload.
module zap_ifetch_skid
    import zap_ifetch_master_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        load,
    input  logic        unload,
    input  logic        flush,
    input  fetch_word_t load_word,
    output fetch_word_t word,
    output logic        full
);

    fetch_word_t word_reg;
    logic        full_reg;

    // Occupancy flag: cleared by reset or flush, set on load, cleared on drain.
    always_ff @(posedge i_clk) begin
        if (i_reset || flush)
            full_reg <= 1'b0;
        else if (load)
            full_reg <= 1'b1;
        else if (unload)
            full_reg <= 1'b0;
    end

    // Payload capture; contents only matter while full_reg is set.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            word_reg <= '0;
        else if (load)
            word_reg <= load_word;
    end

    assign word = word_reg;
    assign full = full_reg;

endmodule

// File: rtl/zap_ifetch_master.sv
// Instruction-side bus master: owns the fetch PC, issues single-word
// reads, and hands words to fetch without loss or duplication across
// stalls, clears and bus errors.
module zap_ifetch_master
    import zap_ifetch_master_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic [31:0] i_pc_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic [31:0] i_pc_from_alu,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    zap_ifetch_master_if.master bus,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc
);

    fetch_state_t    state_reg;
    logic [31:0]     pc_reg;
    logic            stb_reg;
    logic [31:0]     addr_reg;

    fetch_decision_t decision;
    logic            clear;
    logic [31:0]     clear_target;
    logic            resp;
    logic            resp_discard;
    fetch_word_t     resp_word;

    logic            skid_load;
    logic            skid_unload;
    fetch_word_t     skid_word;
    logic            skid_full;

    // Per-cycle decision, response qualification and skid control.
    always_comb begin
        decision     = decide(i_clear_from_writeback, i_data_stall, i_clear_from_alu,
                              i_stall_from_issue, i_stall_from_decode);
        clear        = (decision == DEC_CLR_WB) || (decision == DEC_CLR_ALU);
        clear_target = word_align((decision == DEC_CLR_WB) ? i_pc_from_writeback
                                                           : i_pc_from_alu);
        // Responses only count while a request is actually outstanding.
        resp         = stb_reg && (bus.mem_ack || bus.mem_err);
        // A response to a request issued before a redirect is stale.
        resp_discard = clear || (state_reg == ST_DRAIN);
        // err wins over ack.
        resp_word.instr = bus.mem_err ? ABORT_PAYLOAD : bus.mem_data;
        resp_word.fault = bus.mem_err;
        resp_word.pc    = addr_reg;
        skid_load    = (decision == DEC_HOLD) && resp && !resp_discard;
        skid_unload  = (decision == DEC_ADV) && skid_full;
    end

    zap_ifetch_skid u_skid (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (clear),
        .load_word (resp_word),
        .word      (skid_word),
        .full      (skid_full)
    );

    // Bus FSM: PC ownership, strobe and address with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_VECTOR;
            stb_reg   <= 1'b0;
            addr_reg  <= RESET_VECTOR;
        end else if (clear) begin
            pc_reg <= clear_target;
            if (stb_reg && !resp) begin
                // Keep the old request alive until the bus answers it.
                state_reg <= ST_DRAIN;
            end else begin
                state_reg <= ST_FETCH;
                stb_reg   <= 1'b1;
                addr_reg  <= clear_target;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_FETCH;
                    stb_reg   <= 1'b1;
                    addr_reg  <= pc_reg;
                end
                ST_FETCH: begin
                    if (resp) begin
                        if (bus.mem_err) begin
                            // Faulting address stays in pc; wait for a clear.
                            state_reg <= ST_ABORTED;
                            stb_reg   <= 1'b0;
                        end else begin
                            pc_reg <= pc_reg + WORD_BYTES;
                            if (decision == DEC_HOLD) begin
                                // Skid now holds this word; stop requesting.
                                state_reg <= ST_STALLED;
                                stb_reg   <= 1'b0;
                            end else begin
                                addr_reg <= pc_reg + WORD_BYTES;
                            end
                        end
                    end
                end
                ST_STALLED: begin
                    if (decision == DEC_ADV) begin
                        state_reg <= ST_FETCH;
                        stb_reg   <= 1'b1;
                        addr_reg  <= pc_reg;
                    end
                end
                ST_DRAIN: begin
                    if (resp) begin
                        state_reg <= ST_FETCH;
                        stb_reg   <= 1'b1;
                        addr_reg  <= pc_reg;
                    end
                end
                ST_ABORTED: begin
                    stb_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    stb_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Toward fetch: update only on clear or advance; hold freezes everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid       <= 1'b0;
            o_instr_abort <= 1'b0;
            o_instruction <= '0;
            o_pc          <= RESET_VECTOR;
        end else begin
            case (decision)
                DEC_CLR_WB, DEC_CLR_ALU: begin
                    o_valid       <= 1'b0;
                    o_instr_abort <= 1'b0;
                end
                DEC_ADV: begin
                    if (skid_full) begin
                        o_instruction <= skid_word.instr;
                        o_instr_abort <= skid_word.fault;
                        o_valid       <= !skid_word.fault;
                        o_pc          <= skid_word.pc;
                    end else if (resp && !resp_discard) begin
                        o_instruction <= resp_word.instr;
                        o_instr_abort <= resp_word.fault;
                        o_valid       <= !resp_word.fault;
                        o_pc          <= resp_word.pc;
                    end else begin
                        o_valid       <= 1'b0;
                        o_instr_abort <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_stb  = stb_reg;
    assign bus.mem_addr = addr_reg;

endmodule

// File: tb/tb_zap_ifetch_master.sv
// Bench for zap_ifetch_master: directed scenarios followed by a random
// run, all checked against a stream-level model (fetch must see the
// consecutive words from the last redirect target, each exactly once).
module tb_zap_ifetch_master;

    localparam logic [31:0] DATA_XOR = 32'hA5A5_0000;
    localparam logic [31:0] RV2      = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clr_wb;
    logic [31:0] pc_wb;
    logic        data_stall;
    logic        clr_alu;
    logic [31:0] pc_alu;
    logic        stall_issue;
    logic        stall_decode;
    logic [31:0] o_instruction;
    logic        o_valid;
    logic        o_instr_abort;
    logic [31:0] o_pc;

    logic        tie0;
    logic [31:0] tie0_32;
    logic [31:0] instr2;
    logic        valid2;
    logic        abort2;
    logic [31:0] pc2;

    zap_ifetch_master_if bus ();
    zap_ifetch_master_if bus2 ();

    zap_ifetch_master #(.RESET_VECTOR(32'h0000_0000)) dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_clear_from_writeback (clr_wb),
        .i_pc_from_writeback    (pc_wb),
        .i_data_stall           (data_stall),
        .i_clear_from_alu       (clr_alu),
        .i_pc_from_alu          (pc_alu),
        .i_stall_from_issue     (stall_issue),
        .i_stall_from_decode    (stall_decode),
        .bus                    (bus),
        .o_instruction          (o_instruction),
        .o_valid                (o_valid),
        .o_instr_abort          (o_instr_abort),
        .o_pc                   (o_pc)
    );

    zap_ifetch_master #(.RESET_VECTOR(RV2)) dut_wrap (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_clear_from_writeback (tie0),
        .i_pc_from_writeback    (tie0_32),
        .i_data_stall           (tie0),
        .i_clear_from_alu       (tie0),
        .i_pc_from_alu          (tie0_32),
        .i_stall_from_issue     (tie0),
        .i_stall_from_decode    (tie0),
        .bus                    (bus2),
        .o_instruction          (instr2),
        .o_valid                (valid2),
        .o_instr_abort          (abort2),
        .o_pc                   (pc2)
    );

    int          n_cmp = 0;
    int          n_err = 0;

    // Memory behaviour: 0 = ack every request, 1 = random, 2 = never answer.
    int          mem_mode;
    logic        err_arm;
    logic [31:0] err_addr;

    // Stream-level reference state.
    logic [31:0] exp_pc;
    bit          stale_out;
    bit          abort_wait;
    int          delivered;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: present the memory response, advance, then check.
    task automatic cycle();
        logic [31:0] s_instr, s_pc, s_addr, tgt;
        logic        s_valid, s_abort, s_stb, resp, rerr, was_stale;
        logic        cwb, calu, hold, clear;

        bus.mem_ack  = 1'b0;
        bus.mem_err  = 1'b0;
        bus.mem_data = $urandom;
        if (bus.mem_stb === 1'b1) begin
            if (mem_mode == 0)
                bus.mem_ack = 1'b1;
            else if (mem_mode == 1)
                bus.mem_ack = ($urandom_range(0, 1) == 1);
            if (bus.mem_ack) begin
                bus.mem_data = bus.mem_addr ^ DATA_XOR;
                if (err_arm && bus.mem_addr == err_addr) begin
                    bus.mem_err = 1'b1;
                    err_arm     = 1'b0;
                end else if (mem_mode == 1 && $urandom_range(0, 39) == 0) begin
                    bus.mem_err = 1'b1;
                end
                if (bus.mem_err && $urandom_range(0, 1) == 0)
                    bus.mem_ack = 1'b0;
            end
        end
        bus2.mem_ack  = (bus2.mem_stb === 1'b1);
        bus2.mem_err  = 1'b0;
        bus2.mem_data = bus2.mem_addr ^ DATA_XOR;

        s_instr = o_instruction;
        s_pc    = o_pc;
        s_valid = o_valid;
        s_abort = o_instr_abort;
        s_stb   = bus.mem_stb;
        s_addr  = bus.mem_addr;
        resp    = (s_stb === 1'b1) && (bus.mem_ack || bus.mem_err);
        rerr    = bus.mem_err;

        @(posedge clk);
        #1;

        if (reset) begin
            exp_pc     = 32'h0;
            stale_out  = 1'b0;
            abort_wait = 1'b0;
            return;
        end

        cwb   = clr_wb;
        calu  = !clr_wb && !data_stall && clr_alu;
        clear = cwb || calu;
        hold  = !clear && (data_stall || stall_issue || stall_decode);
        tgt   = cwb ? pc_wb : pc_alu;

        was_stale = stale_out;
        if (clear)
            stale_out = resp ? 1'b0 : s_stb;
        else if (resp)
            stale_out = 1'b0;
        if (clear)
            abort_wait = 1'b0;
        else if (resp && rerr && !was_stale)
            abort_wait = 1'b1;

        if (s_stb && !resp) begin
            chk("bus_stb_held", 32'(bus.mem_stb), 32'd1);
            chk("bus_addr_stable", bus.mem_addr, s_addr);
        end
        if (abort_wait)
            chk("stb_low_after_err", 32'(bus.mem_stb), 32'd0);

        if (clear) begin
            exp_pc = tgt & 32'hFFFF_FFFC;
            chk("clear_valid", 32'(o_valid), 32'd0);
            chk("clear_abort", 32'(o_instr_abort), 32'd0);
        end else if (hold) begin
            chk("hold_valid", 32'(o_valid), 32'(s_valid));
            chk("hold_abort", 32'(o_instr_abort), 32'(s_abort));
            chk("hold_instr", o_instruction, s_instr);
            chk("hold_pc", o_pc, s_pc);
        end else if (o_valid === 1'b1) begin
            chk("adv_abort_low", 32'(o_instr_abort), 32'd0);
            chk("adv_pc", o_pc, exp_pc);
            chk("adv_instr", o_instruction, exp_pc ^ DATA_XOR);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end else if (o_instr_abort === 1'b1) begin
            chk("abort_pc", o_pc, exp_pc);
            chk("abort_instr", o_instruction, 32'd0);
        end
    endtask

    initial begin
        tie0         = 1'b0;
        tie0_32      = 32'd0;
        reset        = 1'b1;
        clr_wb       = 1'b0;
        pc_wb        = 32'd0;
        data_stall   = 1'b0;
        clr_alu      = 1'b0;
        pc_alu       = 32'd0;
        stall_issue  = 1'b0;
        stall_decode = 1'b0;
        mem_mode     = 0;
        err_arm      = 1'b0;
        err_addr     = 32'd0;
        delivered    = 0;
        bus.mem_ack  = 1'b0;
        bus.mem_err  = 1'b0;
        bus.mem_data = 32'd0;
        bus2.mem_ack  = 1'b0;
        bus2.mem_err  = 1'b0;
        bus2.mem_data = 32'd0;

        // Reset values.
        cycle();
        cycle();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_abort", 32'(o_instr_abort), 32'd0);
        chk("rst_instr", o_instruction, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_stb", 32'(bus.mem_stb), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wrap_pc", pc2, RV2);
        chk("rst_wrap_addr", bus2.mem_addr, RV2);

        // Streaming with an ack every cycle; wrap instance runs alongside.
        reset = 1'b0;
        cycle();
        chk("first_stb", 32'(bus.mem_stb), 32'd1);
        chk("first_addr", bus.mem_addr, 32'd0);
        cycle();
        chk("seq_pc0", o_pc, 32'h0);
        chk("seq_valid0", 32'(o_valid), 32'd1);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        cycle();
        chk("seq_pc4", o_pc, 32'h4);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        chk("wrap_addr", bus2.mem_addr, 32'h0);
        cycle();
        chk("seq_pc8", o_pc, 32'h8);
        cycle();
        chk("seq_pcC", o_pc, 32'hC);

        // Decode stall for 3 cycles while the 0x8 ack lands.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
        cycle();
        stall_decode = 1'b1;
        cycle();
        chk("stall_pc_frozen", o_pc, 32'h4);
        chk("stall_stb_low", 32'(bus.mem_stb), 32'd0);
        cycle();
        cycle();
        chk("stall_pc_still", o_pc, 32'h4);
        stall_decode = 1'b0;
        cycle();
        chk("skid_pc8", o_pc, 32'h8);
        chk("skid_valid", 32'(o_valid), 32'd1);
        cycle();
        chk("after_skid_pcC", o_pc, 32'hC);

        // ALU clear to 0x103 while the 0x10 request is unanswered.
        mem_mode = 2;
        cycle();
        chk("gap_valid", 32'(o_valid), 32'd0);
        clr_alu = 1'b1;
        pc_alu  = 32'h103;
        cycle();
        clr_alu = 1'b0;
        chk("drain_stb", 32'(bus.mem_stb), 32'd1);
        chk("drain_addr", bus.mem_addr, 32'h10);
        cycle();
        mem_mode = 0;
        cycle();
        chk("drain_discard", 32'(o_valid), 32'd0);
        chk("redirect_addr", bus.mem_addr, 32'h100);
        cycle();
        chk("redirect_pc", o_pc, 32'h100);
        chk("redirect_valid", 32'(o_valid), 32'd1);

        // Simultaneous clears: writeback target wins.
        clr_wb  = 1'b1;
        pc_wb   = 32'h18;
        clr_alu = 1'b1;
        pc_alu  = 32'h40;
        cycle();
        clr_wb  = 1'b0;
        clr_alu = 1'b0;
        chk("dual_clear_addr", bus.mem_addr, 32'h18);
        cycle();
        chk("dual_clear_pc", o_pc, 32'h18);

        // Bus error on 0x20, then writeback clear to 0x1C.
        err_arm  = 1'b1;
        err_addr = 32'h20;
        cycle();
        chk("pre_err_pc", o_pc, 32'h1C);
        cycle();
        chk("err_abort", 32'(o_instr_abort), 32'd1);
        chk("err_valid", 32'(o_valid), 32'd0);
        chk("err_instr", o_instruction, 32'd0);
        chk("err_pc", o_pc, 32'h20);
        cycle();
        cycle();
        chk("aborted_stb", 32'(bus.mem_stb), 32'd0);
        clr_wb = 1'b1;
        pc_wb  = 32'h1C;
        cycle();
        clr_wb = 1'b0;
        chk("resume_stb", 32'(bus.mem_stb), 32'd1);
        chk("resume_addr", bus.mem_addr, 32'h1C);
        cycle();
        chk("resume_pc", o_pc, 32'h1C);
        chk("resume_valid", 32'(o_valid), 32'd1);

        // Random traffic against the stream model.
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        mem_mode  = 1;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            clr_wb       = ($urandom_range(0, 24) == 0);
            data_stall   = ($urandom_range(0, 5) == 0);
            clr_alu      = ($urandom_range(0, 19) == 0);
            stall_issue  = ($urandom_range(0, 7) == 0);
            stall_decode = ($urandom_range(0, 7) == 0);
            pc_wb        = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
            pc_alu       = $urandom;
            cycle();
        end
        data_stall   = 1'b0;
        clr_alu      = 1'b0;
        stall_issue  = 1'b0;
        stall_decode = 1'b0;
        clr_wb       = 1'b1;
        pc_wb        = 32'h200;
        cycle();
        clr_wb   = 1'b0;
        mem_mode = 0;
        for (int i = 0; i < 10; i++)
            cycle();
        chk("random_progress", 32'(delivered > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
